// File: rtl/sap_pkg.sv
// Shared definitions for the program loader slice.
// Provides the RAM geometry, the controller opcodes the bench uses
// and the state encodings for the loader and its byte packer.
package sap_pkg;

    localparam int RAM_ADDR_WIDTH = 4;
    localparam int RAM_WORD_WIDTH = 16;

    localparam logic [7:0] OP_JMP = 8'd6;
    localparam logic [7:0] OP_JC  = 8'd7;
    localparam logic [7:0] OP_JZ  = 8'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECV_HI,
        ST_RECV_LO,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_DONE
    } loader_state_t;

    typedef enum logic [1:0] {
        PK_EMPTY,
        PK_HI,
        PK_LO
    } packer_state_t;

endpackage

// File: rtl/loader_byte_packer.sv
// Byte-to-word packer for the program loader.
// Ports:
//   i_clock, i_reset  clock and synchronous active-high reset
//   i_valid, i_data   incoming byte stream
//   o_ready           a byte is accepted on any edge with i_valid && o_ready
//   o_word            assembled {high byte, low byte}
//   o_word_valid      high on the edge that accepts the low byte
//   i_word_taken      previous word consumed; arm for the next high byte
module loader_byte_packer
    import sap_pkg::*;
(
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    input  logic [7:0]                i_data,
    output logic                      o_ready,
    output logic [RAM_WORD_WIDTH-1:0] o_word,
    output logic                      o_word_valid,
    input  logic                      i_word_taken
);

    packer_state_t state_q, state_d;

    // Ready is decoded from the state register only, so it never
    // depends combinationally on i_valid.
    assign o_ready      = (state_q != PK_EMPTY);
    assign o_word_valid = (state_q == PK_LO) && i_valid;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PK_EMPTY: if (i_word_taken) state_d = PK_HI;
            PK_HI:    if (i_valid)      state_d = PK_LO;
            PK_LO:    if (i_valid)      state_d = PK_EMPTY;
            default:                    state_d = PK_EMPTY;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= PK_EMPTY;
            o_word  <= '0;
        end else begin
            state_q <= state_d;
            if (i_valid && state_q == PK_HI) o_word[15:8] <= i_data;
            if (i_valid && state_q == PK_LO) o_word[7:0]  <= i_data;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: streams bytes into 16-bit words and writes them to
// sequential RAM addresses from 0, holding the CPU in reset meanwhile.
// Ports:
//   i_clock, i_reset        clock and synchronous active-high reset
//   i_debug                 trace request; no functional effect in RTL
//   i_start, i_length       begin a load of i_length words (1..DEPTH)
//   i_valid, i_data, o_ready  byte stream handshake
//   o_program_mode, o_program_address, o_program_data, o_write_enable
//                           RAM program-port drive
//   o_cpu_reset             holds pc/registers/controller in reset
//   o_busy, o_done, o_error status
module program_loader
    import sap_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int WORD_WIDTH = RAM_WORD_WIDTH,
    parameter int WRITE_HOLD = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_debug,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_length,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    output logic                  o_ready,
    output logic                  o_program_mode,
    output logic [ADDR_WIDTH-1:0] o_program_address,
    output logic [WORD_WIDTH-1:0] o_program_data,
    output logic                  o_write_enable,
    output logic                  o_cpu_reset,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error
);

    localparam int          LEN_W     = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  HOLD_LAST = 4'(WRITE_HOLD - 1);

    loader_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_W-1:0]      word_cnt_q;
    logic [LEN_W-1:0]      length_q;
    logic [3:0]            hold_cnt_q;
    logic                  error_q;

    logic start_ok;
    logic last_word;
    logic pk_ready;
    logic pk_word_valid;
    logic word_taken;

    // Word tracing is done by the bench; the input is kept for pin
    // compatibility only.
    logic unused_debug;
    assign unused_debug = i_debug;

    assign start_ok  = i_start && (i_length != '0) && (i_length <= LEN_W'(DEPTH));
    assign last_word = (word_cnt_q + LEN_W'(1)) == length_q;

    // The packer is armed when a load starts and again after each
    // non-final word, so it only accepts bytes while we are in RECV_*.
    assign word_taken = ((state_q == ST_IDLE) && start_ok) ||
                        ((state_q == ST_HOLD) && !last_word);

    loader_byte_packer u_packer (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_valid      (i_valid),
        .i_data       (i_data),
        .o_ready      (pk_ready),
        .o_word       (o_program_data),
        .o_word_valid (pk_word_valid),
        .i_word_taken (word_taken)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_ok)            state_d = ST_RECV_HI;
            ST_RECV_HI: if (i_valid && pk_ready) state_d = ST_RECV_LO;
            ST_RECV_LO: if (pk_word_valid)       state_d = ST_SETUP;
            ST_SETUP:                            state_d = ST_PULSE;
            ST_PULSE:   if (hold_cnt_q == HOLD_LAST) state_d = ST_HOLD;
            ST_HOLD:    state_d = last_word ? ST_DONE : ST_RECV_HI;
            ST_DONE:                             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    assign o_ready           = pk_ready;
    assign o_busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign o_cpu_reset       = o_busy;
    assign o_program_mode    = o_busy;
    assign o_write_enable    = (state_q == ST_PULSE);
    assign o_done            = (state_q == ST_DONE);
    assign o_error           = error_q;
    assign o_program_address = addr_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            word_cnt_q <= '0;
            length_q   <= '0;
            hold_cnt_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            error_q <= (state_q == ST_IDLE) && i_start && !start_ok;
            unique case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        length_q   <= i_length;
                        addr_q     <= '0;
                        word_cnt_q <= '0;
                    end
                end
                ST_SETUP: hold_cnt_q <= '0;
                ST_PULSE: hold_cnt_q <= hold_cnt_q + 4'd1;
                ST_HOLD: begin
                    word_cnt_q <= word_cnt_q + LEN_W'(1);
                    if (!last_word) addr_q <= addr_q + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;
    import sap_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_debug = 1'b0;
    logic        i_start = 1'b0;
    logic [4:0]  i_length = '0;
    logic        i_valid = 1'b0;
    logic [7:0]  i_data = '0;
    logic        o_ready, o_program_mode, o_write_enable;
    logic        o_cpu_reset, o_busy, o_done, o_error;
    logic [3:0]  o_program_address;
    logic [15:0] o_program_data;

    program_loader #(.ADDR_WIDTH(4), .WORD_WIDTH(16), .WRITE_HOLD(2)) dut (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_debug           (i_debug),
        .i_start           (i_start),
        .i_length          (i_length),
        .i_valid           (i_valid),
        .i_data            (i_data),
        .o_ready           (o_ready),
        .o_program_mode    (o_program_mode),
        .o_program_address (o_program_address),
        .o_program_data    (o_program_data),
        .o_write_enable    (o_write_enable),
        .o_cpu_reset       (o_cpu_reset),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_error           (o_error)
    );

    always #5 i_clock = ~i_clock;

    int n_vectors = 0;
    int n_miscompares = 0;

    logic [15:0] ram_model [16];
    logic [15:0] prog [16];
    int we_cycles, we_rises, done_pulses, cr_cycles, addr0_writes;
    int cyc, last_we_cycle, done_cycle, gap_ready_low;
    logic we_prev;
    logic [3:0] last_we_addr;

    // RAM model and activity counters, sampled on the write edge.
    always @(posedge i_clock) begin
        cyc <= cyc + 1;
        we_prev <= o_write_enable;
        if (o_write_enable) begin
            ram_model[o_program_address] <= o_program_data;
            we_cycles     <= we_cycles + 1;
            last_we_cycle <= cyc;
            last_we_addr  <= o_program_address;
            if (!we_prev) begin
                we_rises <= we_rises + 1;
                if (o_program_address == 4'd0) addr0_writes <= addr0_writes + 1;
            end
        end
        if (o_done) begin
            done_pulses <= done_pulses + 1;
            done_cycle  <= cyc;
        end
        if (o_cpu_reset) cr_cycles <= cr_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic clear_counters();
        we_cycles = 0; we_rises = 0; done_pulses = 0; cr_cycles = 0;
        addr0_writes = 0; gap_ready_low = 0; last_we_cycle = 0; done_cycle = 0;
    endtask

    function automatic logic [31:0] all_outputs();
        return {5'b0, o_ready, o_program_mode, o_program_address, o_program_data,
                o_write_enable, o_cpu_reset, o_busy, o_done, o_error};
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap, input bit hi);
        int n;
        i_valid = 1'b1;
        i_data  = b;
        n = 0;
        while (!o_ready && n < 50) begin
            tick();
            n++;
        end
        if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
        tick();
        i_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            tick();
            if (hi && !o_ready) gap_ready_low++;
        end
    endtask

    task automatic start_load(input int len);
        i_length = 5'(len);
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
        i_length = '0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!o_done && n < 40) begin
            tick();
            n++;
        end
        check("done_seen", 32'(o_done), 32'd1);
        tick();
    endtask

    task automatic load(input int len, input int gap);
        clear_counters();
        start_load(len);
        for (int w = 0; w < len; w++) begin
            send_byte(prog[w][15:8], gap, 1'b1);
            send_byte(prog[w][7:0], gap, 1'b0);
        end
        wait_done();
    endtask

    task automatic set_basic_prog();
        prog[0] = 16'h00FF;
        prog[1] = 16'h017F;
        prog[2] = 16'h0201;
        prog[3] = {OP_JC, 8'h02};
    endtask

    task automatic check_basic_ram(input string tag);
        check({tag, "_w0"}, 32'(ram_model[0]), 32'h00FF);
        check({tag, "_w1"}, 32'(ram_model[1]), 32'h017F);
        check({tag, "_w2"}, 32'(ram_model[2]), 32'h0201);
        check({tag, "_w3"}, 32'(ram_model[3]), 32'h0702);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram_model[i] = '0;
            prog[i] = '0;
        end
        cyc = 0;
        we_prev = 1'b0;
        last_we_addr = '0;
        clear_counters();

        // Reset state
        tick();
        tick();
        check("reset_outputs", all_outputs(), 32'd0);
        i_reset = 1'b0;
        tick();
        check("idle_outputs", all_outputs(), 32'd0);

        // Basic load, valid held high
        set_basic_prog();
        clear_counters();
        start_load(4);
        check("cpu_reset_after_start", 32'(o_cpu_reset), 32'd1);
        check("busy_after_start", 32'(o_busy), 32'd1);
        for (int w = 0; w < 4; w++) begin
            send_byte(prog[w][15:8], 0, 1'b1);
            send_byte(prog[w][7:0], 0, 1'b0);
        end
        wait_done();
        check_basic_ram("basic");
        check("basic_we_cycles", 32'(we_cycles), 32'd8);
        check("basic_we_rises", 32'(we_rises), 32'd4);
        check("basic_done_pulses", 32'(done_pulses), 32'd1);
        check("basic_cpu_reset_cycles", 32'(cr_cycles), 32'd24);
        check("basic_idle_after", {o_busy, o_cpu_reset, o_program_mode}, 32'd0);

        // Gapped stream
        for (int i = 0; i < 16; i++) ram_model[i] = '0;
        load(4, 3);
        check_basic_ram("gap");
        check("gap_ready_held", 32'(gap_ready_low), 32'd0);
        check("gap_we_cycles", 32'(we_cycles), 32'd8);
        check("gap_done_pulses", 32'(done_pulses), 32'd1);

        // Illegal lengths
        clear_counters();
        for (int k = 0; k < 2; k++) begin
            i_length = (k == 0) ? 5'd0 : 5'd17;
            i_start  = 1'b1;
            tick();
            i_start  = 1'b0;
            check("illegal_error_pulse", 32'(o_error), 32'd1);
            check("illegal_busy", 32'(o_busy), 32'd0);
            tick();
            check("illegal_error_clears", 32'(o_error), 32'd0);
        end
        tick();
        check("illegal_no_writes", 32'(we_cycles), 32'd0);

        // Full depth
        for (int i = 0; i < 16; i++) prog[i] = 16'(i);
        for (int i = 0; i < 16; i++) ram_model[i] = 16'hDEAD;
        load(16, 0);
        check("full_rises", 32'(we_rises), 32'd16);
        check("full_last_addr", 32'(last_we_addr), 32'd15);
        check("full_no_wrap", 32'(addr0_writes), 32'd1);
        check("full_done_after_hold", 32'(done_cycle - last_we_cycle), 32'd2);
        check("full_w0", 32'(ram_model[0]), 32'h0000);
        check("full_w9", 32'(ram_model[9]), 32'h0009);
        check("full_w15", 32'(ram_model[15]), 32'h000F);

        // Reset during PULSE of word 2
        set_basic_prog();
        for (int i = 0; i < 16; i++) ram_model[i] = '0;
        clear_counters();
        start_load(4);
        for (int w = 0; w < 3; w++) begin
            send_byte(prog[w][15:8], 0, 1'b1);
            send_byte(prog[w][7:0], 0, 1'b0);
        end
        begin
            int n;
            n = 0;
            while (!o_write_enable && n < 20) begin
                tick();
                n++;
            end
        end
        check("midreset_in_pulse", {o_write_enable, 4'(o_program_address)}, {1'b1, 4'd2});
        i_reset = 1'b1;
        tick();
        check("midreset_outputs", all_outputs(), 32'd0);
        i_reset = 1'b0;
        tick();
        check("midreset_idle", all_outputs(), 32'd0);
        check("midreset_kept_w1", 32'(ram_model[1]), 32'h017F);
        prog[0] = 16'hAA55;
        load(1, 0);
        check("reload_w0", 32'(ram_model[0]), 32'hAA55);
        check("reload_done", 32'(done_pulses), 32'd1);
        check("reload_writes", 32'(we_rises), 32'd1);

        // Start pulse while busy is ignored
        set_basic_prog();
        for (int i = 0; i < 16; i++) ram_model[i] = '0;
        clear_counters();
        start_load(4);
        send_byte(prog[0][15:8], 0, 1'b1);
        i_start  = 1'b1;
        i_length = 5'd2;
        send_byte(prog[0][7:0], 0, 1'b0);
        i_start  = 1'b0;
        i_length = '0;
        for (int w = 1; w < 4; w++) begin
            send_byte(prog[w][15:8], 0, 1'b1);
            send_byte(prog[w][7:0], 0, 1'b0);
        end
        wait_done();
        check_basic_ram("busy_start");
        check("busy_start_rises", 32'(we_rises), 32'd4);
        check("busy_start_done", 32'(done_pulses), 32'd1);
        check("busy_start_no_error", 32'(o_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
